vme_bus_arbiter: RTL and testbench
==================================

// Module: vme_bus_arbiter
// PURPOSE
//  Parametrised VME system-controller bus arbiter for the systemboard CPLD.
//  Arbitrates NUM_LEVELS active-low bus-request lines and drives one active-low
//  grant per level. Tracks BBSY ownership and asserts BCLR to preempt the owner.
//  Selectable fixed-priority (PRI) or round-robin (RRS) mode.
// PARAMETERS
//  NUM_LEVELS     4    request/grant levels, 1..8
//  MODE           0    0 = PRI (level 0 highest), 1 = RRS (rotating)
//  TIMEOUT_CYCLES 255  grant-no-BBSY timeout in clocks (VME_ARB_TIMEOUT_EN only)
// PORTS
//  clock        in   1           system clock, also the VME SYSCLK source
//  reset        in   1           synchronous reset, active-low
//  vme_br       in   NUM_LEVELS  bus requests, active-low, asynchronous
//  vme_bbsy     in   1           bus busy, active-low, asynchronous
//  vme_bgout    out  NUM_LEVELS  bus grants, active-low, registered
//  vme_bclr     out  1           bus clear, active-low, registered
//  owner        out  LEVEL_W     level currently granted/owning (LEVEL_W=max(1,clog2 N))
//  owner_valid  out  1           high in GRANT, BUSY, CLEAR
//  timeout      out  1           one-clock pulse on grant timeout
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, vme_bgout=all 1, vme_bclr=1, owner=0,
//    owner_valid=0, timeout=0, RR pointer=NUM_LEVELS-1; takes effect next edge,
//    mid-operation included (grants/BCLR drop at once).
//  - vme_br, vme_bbsy pass a 2-flop synchronizer (br_s, bbsy_s); all decisions use
//    synced values. BR low -> BG low on 3rd posedge after BR meets setup.
//  - Winner: PRI = lowest active index. RRS = first active index searching from
//    ptr+1 upward with wrap N-1 -> 0; ptr <= winner on grant. Exactly one bgout low.
//  - IDLE: bgout=all 1, bclr=1. If any br_s low AND bbsy_s high: bgout[w]<=0,
//    owner<=w, -> GRANT. bbsy_s low (owner unknown) blocks granting.
//  - GRANT: bbsy_s low -> bgout[owner]<=1, -> BUSY. br_s[owner] high before BBSY
//    (request withdrawn) -> bgout<=all 1, -> IDLE. BBSY wins if both same cycle.
//  - BUSY: bbsy_s high -> IDLE. Else preempt -> bclr<=0, -> CLEAR, where preempt =
//    PRI: any br_s[i] low with i<owner; RRS: any br_s[i] low with i!=owner.
//  - CLEAR: bclr held low until bbsy_s high -> bclr<=1, -> IDLE. New requests
//    ignored here; re-arbitrated from IDLE next cycle (1 dead cycle min).
//  - No grant is ever issued while bbsy_s low; owner stable outside IDLE.
//  - NUM_LEVELS==1: owner fixed 0, preempt never true, RRS == PRI.
//  - Illegal state encoding -> IDLE with all outputs inactive.
// CONFIGURATION
//  VME_ARB_TIMEOUT_EN defined: counter runs in GRANT; reaching TIMEOUT_CYCLES with
//    bbsy_s still high -> bgout<=all 1, timeout pulses 1 clock, -> IDLE. RRS pointer
//    advances past the dead level; PRI may re-grant the same level.
//  Not defined: no counter, GRANT waits indefinitely, timeout tied 0.
// TESTING
//  1 PRI: reset, br=4'b1011 -> 3 clk later bgout=4'b1011, owner=2; bbsy low ->
//    bgout=4'b1111, state BUSY; bbsy high -> IDLE.
//  2 PRI preempt: owner 2 in BUSY, br[0] low -> bclr=0 within 3 clk; bbsy high ->
//    bclr=1, then bgout=4'b1110, owner=0.
//  3 RRS: br=4'b0000 held, each owner takes/releases BBSY -> owners 0,1,2,3,0;
//    bclr low during each BUSY (others pending).
//  4 Simultaneous: BBSY low and br[owner] high same synced cycle in GRANT -> BUSY;
//    br low while external bbsy low in IDLE -> no grant until bbsy high.
//  5 Reset mid-CLEAR: reset low one edge -> bgout=4'b1111, bclr=1, owner_valid=0.
//  6 VME_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: grant, no BBSY -> after 8 clk bgout=1111,
//    timeout=1 one clk; without macro grant held >1000 clk, timeout=0.

Source files
------------

// File: rtl/vme_bus_arbiter_if.sv
// VME arbitration bus bundle: request/busy lines in, grant/clear lines out.
// The master modport is the arbiter's view of the bus.
interface vme_bus_arbiter_if #(
  parameter int unsigned NUM_LEVELS = 4
);
  logic [NUM_LEVELS-1:0] vme_br;
  logic                  vme_bbsy;
  logic [NUM_LEVELS-1:0] vme_bgout;
  logic                  vme_bclr;

  modport master (
    input  vme_br,
    input  vme_bbsy,
    output vme_bgout,
    output vme_bclr
  );

  modport slave (
    output vme_br,
    output vme_bbsy,
    input  vme_bgout,
    input  vme_bclr
  );
endinterface

// File: rtl/vme_bus_arbiter.sv
// VME system-controller bus arbiter with fixed-priority (MODE=0) or round-robin (MODE=1)
// selection. Define VME_ARB_TIMEOUT_EN to drop a grant that never sees BBSY.
module vme_bus_arbiter #(
  parameter int unsigned  NUM_LEVELS     = 4,
  parameter int unsigned  MODE           = 0,
  parameter int unsigned  TIMEOUT_CYCLES = 255,
  localparam int unsigned LEVEL_W        = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  vme_bus_arbiter_if.master   bus,
  output logic [LEVEL_W-1:0]  owner,
  output logic                owner_valid,
  output logic                timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StBusy, StClear} state_e;

  state_e                state_q, state_d;
  logic [NUM_LEVELS-1:0] br_meta_q, br_s_q;
  logic                  bbsy_meta_q, bbsy_s_q;
  logic [NUM_LEVELS-1:0] bgout_q, bgout_d;
  logic                  bclr_q, bclr_d;
  logic [LEVEL_W-1:0]    owner_q, owner_d;
  logic [LEVEL_W-1:0]    ptr_q, ptr_d;
  logic                  owner_valid_q, owner_valid_d;
  logic                  timeout_q, timeout_d;

  logic                  any_req;
  logic [LEVEL_W-1:0]    winner;
  logic                  preempt;

`ifdef VME_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Winner selection on synchronised requests.
  always_comb begin : p_winner
    logic [LEVEL_W-1:0] idx;
    any_req = ~&br_s_q;
    winner  = '0;
    idx     = '0;
    if (MODE == 1) begin
      // Descending scan so the first active level after ptr_q is the last one kept.
      for (int unsigned k = NUM_LEVELS; k >= 1; k--) begin
        idx = LEVEL_W'((32'(ptr_q) + k) % NUM_LEVELS);
        if (!br_s_q[idx]) winner = idx;
      end
    end else begin
      for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
        if (!br_s_q[i]) winner = LEVEL_W'(i);
      end
    end
  end

  always_comb begin
    preempt = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (!br_s_q[i]) begin
        if (MODE == 1) begin
          if (LEVEL_W'(i) != owner_q) preempt = 1'b1;
        end else if (LEVEL_W'(i) < owner_q) begin
          preempt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bgout_d   = bgout_q;
    bclr_d    = bclr_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef VME_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        bgout_d = '1;
        bclr_d  = 1'b1;
`ifdef VME_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        // An asserted BBSY with no known owner blocks any new grant.
        if (any_req && bbsy_s_q) begin
          for (int i = 0; i < NUM_LEVELS; i++) bgout_d[i] = (LEVEL_W'(i) != winner);
          owner_d = winner;
          if (MODE == 1) ptr_d = winner;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!bbsy_s_q) begin
          bgout_d = '1;
          state_d = StBusy;
        end else if (br_s_q[owner_q]) begin
          bgout_d = '1;
          state_d = StIdle;
        end
`ifdef VME_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          bgout_d   = '1;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StBusy: begin
        if (bbsy_s_q) begin
          state_d = StIdle;
        end else if (preempt) begin
          bclr_d  = 1'b0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (bbsy_s_q) begin
          bclr_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        bgout_d = '1;
        bclr_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
    owner_valid_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      br_meta_q     <= '1;
      br_s_q        <= '1;
      bbsy_meta_q   <= 1'b1;
      bbsy_s_q      <= 1'b1;
      state_q       <= StIdle;
      bgout_q       <= '1;
      bclr_q        <= 1'b1;
      owner_q       <= '0;
      ptr_q         <= LEVEL_W'(NUM_LEVELS - 1);
      owner_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef VME_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      br_meta_q     <= bus.vme_br;
      br_s_q        <= br_meta_q;
      bbsy_meta_q   <= bus.vme_bbsy;
      bbsy_s_q      <= bbsy_meta_q;
      state_q       <= state_d;
      bgout_q       <= bgout_d;
      bclr_q        <= bclr_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      owner_valid_q <= owner_valid_d;
      timeout_q     <= timeout_d;
`ifdef VME_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign bus.vme_bgout = bgout_q;
  assign bus.vme_bclr  = bclr_q;
  assign owner         = owner_q;
  assign owner_valid   = owner_valid_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Scoreboard bench: a PRI and an RRS arbiter instance; stimulus queues expected output
// changes with their due cycle, the monitor pops one entry per observed change.
module tb_vme_bus_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vme_bus_arbiter_if #(.NUM_LEVELS(4)) bus_pri ();
  vme_bus_arbiter_if #(.NUM_LEVELS(4)) bus_rrs ();

  logic [1:0] own_pri, own_rrs;
  logic       ov_pri, ov_rrs, to_pri, to_rrs;

  vme_bus_arbiter #(.NUM_LEVELS(4), .MODE(0), .TIMEOUT_CYCLES(8)) u_pri (
    .clock      (clk),
    .reset      (rst_n),
    .bus        (bus_pri),
    .owner      (own_pri),
    .owner_valid(ov_pri),
    .timeout    (to_pri)
  );

  vme_bus_arbiter #(.NUM_LEVELS(4), .MODE(1), .TIMEOUT_CYCLES(8)) u_rrs (
    .clock      (clk),
    .reset      (rst_n),
    .bus        (bus_rrs),
    .owner      (own_rrs),
    .owner_valid(ov_rrs),
    .timeout    (to_rrs)
  );

  typedef struct {
    logic [8:0] val;
    int         due;
  } exp_t;

  exp_t       sb_pri[$];
  exp_t       sb_rrs[$];
  logic [8:0] prev_out[2] = '{9'bx, 9'bx};
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output tuple: {bgout[3:0], bclr, owner_valid, owner[1:0], timeout}
  function automatic logic [8:0] tup(logic [3:0] bg, logic bclr, logic ov, logic [1:0] own,
                                     logic to);
    return {bg, bclr, ov, own, to};
  endfunction

  function automatic logic [3:0] gnt(logic [1:0] lvl);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << lvl);
  endfunction

  task automatic exp_pri(input logic [8:0] v, input int due);
    exp_t e;
    e.val = v;
    e.due = due;
    sb_pri.push_back(e);
  endtask

  task automatic exp_rrs(input logic [8:0] v, input int due);
    exp_t e;
    e.val = v;
    e.due = due;
    sb_rrs.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_dut(input int d, input logic [8:0] act);
    exp_t e;
    int   pending;
    pending = (d == 0) ? sb_pri.size() : sb_rrs.size();
    if (act !== prev_out[d]) begin
      prev_out[d] = act;
      n_checks++;
      if (pending == 0) begin
        n_fail++;
        $display("FAIL dut%0d_unexpected_change: got %b at cycle %0d, required no change",
                 d, act, cyc);
      end else begin
        if (d == 0) e = sb_pri.pop_front();
        else e = sb_rrs.pop_front();
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL dut%0d_outputs: got %b, required %b (cycle %0d)", d, act, e.val, cyc);
        end
        n_checks++;
        if (cyc != e.due) begin
          n_fail++;
          $display("FAIL dut%0d_latency: change at cycle %0d, required cycle %0d",
                   d, cyc, e.due);
        end
      end
    end else if (pending != 0) begin
      if (d == 0) e = sb_pri[0];
      else e = sb_rrs[0];
      if (cyc > e.due) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d_missing: got %b unchanged at cycle %0d, required %b by cycle %0d",
                 d, act, cyc, e.val, e.due);
        if (d == 0) void'(sb_pri.pop_front());
        else void'(sb_rrs.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, {bus_pri.vme_bgout, bus_pri.vme_bclr, ov_pri, own_pri, to_pri});
    check_dut(1, {bus_rrs.vme_bgout, bus_rrs.vme_bclr, ov_rrs, own_rrs, to_rrs});
  end

  initial begin
    bus_pri.vme_br   = 4'b1111;
    bus_pri.vme_bbsy = 1'b1;
    bus_rrs.vme_br   = 4'b1111;
    bus_rrs.vme_bbsy = 1'b1;
    exp_pri(tup(4'b1111, 1, 0, 0, 0), 1);
    exp_rrs(tup(4'b1111, 1, 0, 0, 0), 1);
    step(3);
    rst_n = 1'b1;
    step(1);

    // PRI grant, BBSY take, release
    bus_pri.vme_br = 4'b1011;
    exp_pri(tup(4'b1011, 1, 1, 2, 0), cyc + 3);
    step(6);
    bus_pri.vme_bbsy = 1'b0;
    exp_pri(tup(4'b1111, 1, 1, 2, 0), cyc + 3);
    step(6);

    // Higher-priority request preempts owner 2
    bus_pri.vme_br = 4'b1010;
    exp_pri(tup(4'b1111, 0, 1, 2, 0), cyc + 3);
    step(6);
    bus_pri.vme_bbsy = 1'b1;
    exp_pri(tup(4'b1111, 1, 0, 2, 0), cyc + 3);
    exp_pri(tup(4'b1110, 1, 1, 0, 0), cyc + 4);
    step(6);
    bus_pri.vme_br = 4'b1111;
    exp_pri(tup(4'b1111, 1, 0, 0, 0), cyc + 3);
    step(6);

    // BBSY and request withdrawal in the same synced cycle: BBSY wins
    bus_pri.vme_br = 4'b1101;
    exp_pri(tup(4'b1101, 1, 1, 1, 0), cyc + 3);
    step(6);
    bus_pri.vme_br   = 4'b1111;
    bus_pri.vme_bbsy = 1'b0;
    exp_pri(tup(4'b1111, 1, 1, 1, 0), cyc + 3);
    step(6);
    bus_pri.vme_bbsy = 1'b1;
    exp_pri(tup(4'b1111, 1, 0, 1, 0), cyc + 3);
    step(6);

    // Foreign BBSY in IDLE blocks granting
    bus_pri.vme_bbsy = 1'b0;
    step(4);
    bus_pri.vme_br = 4'b0111;
    step(6);
    bus_pri.vme_bbsy = 1'b1;
    exp_pri(tup(4'b0111, 1, 1, 3, 0), cyc + 3);
    step(6);
    bus_pri.vme_br = 4'b1111;
    exp_pri(tup(4'b1111, 1, 0, 3, 0), cyc + 3);
    step(6);

    // Reset in the middle of CLEAR
    bus_pri.vme_br = 4'b1101;
    exp_pri(tup(4'b1101, 1, 1, 1, 0), cyc + 3);
    step(6);
    bus_pri.vme_bbsy = 1'b0;
    exp_pri(tup(4'b1111, 1, 1, 1, 0), cyc + 3);
    step(6);
    bus_pri.vme_br = 4'b1100;
    exp_pri(tup(4'b1111, 0, 1, 1, 0), cyc + 3);
    step(6);
    rst_n = 1'b0;
    exp_pri(tup(4'b1111, 1, 0, 0, 0), cyc + 1);
    step(1);
    rst_n = 1'b1;
    step(8);
    bus_pri.vme_br   = 4'b1111;
    bus_pri.vme_bbsy = 1'b1;
    step(8);

    // Grant with no BBSY
    bus_pri.vme_br = 4'b1110;
    exp_pri(tup(4'b1110, 1, 1, 0, 0), cyc + 3);
`ifdef VME_ARB_TIMEOUT_EN
    exp_pri(tup(4'b1111, 1, 0, 0, 1), cyc + 11);
    exp_pri(tup(4'b1110, 1, 1, 0, 0), cyc + 12);
    step(12);
`else
    step(1100);
`endif
    bus_pri.vme_br = 4'b1111;
    exp_pri(tup(4'b1111, 1, 0, 0, 0), cyc + 3);
    step(6);

    // RRS rotation with every level requesting
    bus_rrs.vme_br = 4'b0000;
    exp_rrs(tup(4'b1110, 1, 1, 0, 0), cyc + 3);
    step(6);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] o, n;
      o = 2'(k);
      n = 2'(k + 1);
      bus_rrs.vme_bbsy = 1'b0;
      exp_rrs(tup(4'b1111, 1, 1, o, 0), cyc + 3);
      exp_rrs(tup(4'b1111, 0, 1, o, 0), cyc + 4);
      step(6);
      bus_rrs.vme_bbsy = 1'b1;
      exp_rrs(tup(4'b1111, 1, 0, o, 0), cyc + 3);
      exp_rrs(tup(gnt(n), 1, 1, n, 0), cyc + 4);
      step(6);
    end
    bus_rrs.vme_br = 4'b1111;
    exp_rrs(tup(4'b1111, 1, 0, 0, 0), cyc + 3);
    step(10);

    while (sb_pri.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut0_leftover: got no change, required %b by cycle %0d",
               sb_pri[0].val, sb_pri[0].due);
      void'(sb_pri.pop_front());
    end
    while (sb_rrs.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut1_leftover: got no change, required %b by cycle %0d",
               sb_rrs[0].val, sb_rrs[0].due);
      void'(sb_rrs.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
